// File: rtl/stopwatch_ctrl_if.sv
// Command, tick and display signals between the stopwatch controller and its
// neighbours (debouncers, base timer, display driver).
interface stopwatch_ctrl_if;
  logic        i_start_stop;
  logic        i_lap;
  logic        i_clear;
  logic        i_base_tick;
  logic        o_timerenb;
  logic        o_timer_reset_n;
  logic [23:0] o_disp_bcd;
  logic        o_running;
  logic        o_lap_active;
  logic        o_overflow;

  modport master (
    output i_start_stop, i_lap, i_clear, i_base_tick,
    input  o_timerenb, o_timer_reset_n, o_disp_bcd, o_running, o_lap_active, o_overflow
  );

  modport slave (
    input  i_start_stop, i_lap, i_clear, i_base_tick,
    output o_timerenb, o_timer_reset_n, o_disp_bcd, o_running, o_lap_active, o_overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: drives the 10 ms base timer and counts its toggles into BCD MM:SS.cc.
// The lap-freeze display is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl (
  input  logic            i_sclk,
  input  logic            i_reset,
  stopwatch_ctrl_if.slave bus
);
  localparam int unsigned DIGITS = 6;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam logic [BCD_W-1:0] DIG_MAX = 24'h595999;

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, LAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  logic [BCD_W-1:0] cnt_q, cnt_d, cnt_inc, disp_q, disp_d;
  logic             tick_prev_q, tick_evt, counting, wrap;
  logic             ovf_q, ovf_d, enb_q, rstn_q, run_q, active_d;
`ifdef STOPWATCH_LAP_EN
  logic [BCD_W-1:0] lap_q, lap_d;
  logic             lapa_q;
`else
  logic             unused_lap;
  assign unused_lap = bus.i_lap;
`endif

  // Ripple increment; returns {wrap_out, value}. Digits saturate-to-zero at their own limit.
  function automatic logic [BCD_W:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= DIG_MAX[4*i +: 4]) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return {carry, r};
  endfunction

  // Next state, count and registered-output values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    {wrap, cnt_inc} = bcd_inc(cnt_q);
    tick_evt = bus.i_base_tick ^ tick_prev_q;
`ifdef STOPWATCH_LAP_EN
    counting = (state_q == RUN) || (state_q == LAP);
`else
    counting = (state_q == RUN);
`endif

    unique case (state_q)
      IDLE:  if (bus.i_start_stop) state_d = RUN;
      RUN: begin
        if (bus.i_start_stop) state_d = PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (bus.i_lap)   state_d = LAP;
`endif
      end
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        if (bus.i_start_stop) state_d = PAUSE;
        else if (bus.i_lap)   state_d = RUN;
      end
`endif
      PAUSE: begin
        if (bus.i_clear)           state_d = IDLE;
        else if (bus.i_start_stop) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (counting && tick_evt) begin
      cnt_d = cnt_inc;
      if (wrap) ovf_d = 1'b1;
    end
    // Clear only exits PAUSE, where no increment can coincide
    if ((state_q == PAUSE) && (state_d == IDLE)) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end

`ifdef STOPWATCH_LAP_EN
    lap_d = lap_q;
    if ((state_d == LAP) && (state_q != LAP)) lap_d = cnt_q;
    disp_d   = (state_d == LAP) ? lap_d : cnt_d;
    active_d = (state_d == RUN) || (state_d == LAP);
`else
    disp_d   = cnt_d;
    active_d = (state_d == RUN);
`endif
  end

  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      disp_q      <= '0;
      tick_prev_q <= 1'b0;
      ovf_q       <= 1'b0;
      enb_q       <= 1'b0;
      rstn_q      <= 1'b0;
      run_q       <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_q       <= '0;
      lapa_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      disp_q      <= disp_d;
      tick_prev_q <= bus.i_base_tick;
      ovf_q       <= ovf_d;
      enb_q       <= active_d;
      rstn_q      <= (state_d != IDLE);
      run_q       <= active_d;
`ifdef STOPWATCH_LAP_EN
      lap_q       <= lap_d;
      lapa_q      <= (state_d == LAP);
`endif
    end
  end

  assign bus.o_timerenb      = enb_q;
  assign bus.o_timer_reset_n = rstn_q;
  assign bus.o_disp_bcd      = disp_q;
  assign bus.o_running       = run_q;
  assign bus.o_overflow      = ovf_q;
`ifdef STOPWATCH_LAP_EN
  assign bus.o_lap_active    = lapa_q;
`else
  assign bus.o_lap_active    = 1'b0;
`endif
endmodule
